// File: rtl/slr_xing_arb.sv
// Round-robin arbiter and credit manager in front of an SLR-crossing register pipeline.
// Grants one requester per cycle while far-side FIFO credits remain, and launches a registered word plus source tag.
module slr_xing_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int CREDITS = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     sreset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     tx_valid,
    output logic [WIDTH-1:0]         tx_data,
    output logic [ID_W-1:0]          tx_id,
    input  logic                     credit_ret,
    output logic [CW-1:0]            credits_avail,
    output logic                     credit_err,
    output logic                     idle
);

    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W:0]    scan;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;
    logic [CW-1:0]    credits_nxt;
    logic             overflow;

    // Scan from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req_ready  = '0;
        grant_idx  = '0;
        grant_data = '0;
        xfer       = 1'b0;
        scan       = '0;
        if (!sreset && credits_avail != '0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, ptr} + (ID_W + 1)'(k);
                if (scan >= (ID_W + 1)'(NUM_REQ))
                    scan = scan - (ID_W + 1)'(NUM_REQ);
                if (!xfer && req_valid[scan[ID_W-1:0]]) begin
                    xfer      = 1'b1;
                    grant_idx = scan[ID_W-1:0];
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer && grant_idx == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                grant_data   = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A transfer and a returned credit in the same cycle cancel out.
    always_comb begin
        credits_nxt = credits_avail;
        overflow    = 1'b0;
        case ({xfer, credit_ret})
            2'b10: credits_nxt = credits_avail - CW'(1);
            2'b01: begin
                if (credits_avail == CREDITS_MAX) overflow = 1'b1;
                else                             credits_nxt = credits_avail + CW'(1);
            end
            default: credits_nxt = credits_avail;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (sreset) begin
            ptr           <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            tx_id         <= '0;
            credits_avail <= CREDITS_MAX;
            credit_err    <= 1'b0;
            idle          <= 1'b1;
        end else begin
            tx_valid      <= xfer;
            credits_avail <= credits_nxt;
            idle          <= (credits_nxt == CREDITS_MAX) && !xfer;
            if (overflow)
                credit_err <= 1'b1;
            if (xfer) begin
                tx_data <= grant_data;
                tx_id   <= grant_idx;
                ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_slr_xing_arb.sv
// Directed bench for slr_xing_arb with NUM_REQ=4, WIDTH=16, CREDITS=8.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_slr_xing_arb;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int CREDITS = 8;

    logic                     clk = 1'b0;
    logic                     sreset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     tx_valid;
    logic [WIDTH-1:0]         tx_data;
    logic [1:0]               tx_id;
    logic                     credit_ret;
    logic [3:0]               credits_avail;
    logic                     credit_err;
    logic                     idle;

    int total = 0;
    int bad   = 0;

    slr_xing_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
        .clk(clk), .sreset(sreset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_id(tx_id),
        .credit_ret(credit_ret), .credits_avail(credits_avail),
        .credit_err(credit_err), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sreset     = 1'b1;
        req_valid  = 4'hF;
        credit_ret = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = 16'(i * 16'h1111);
        #1;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        tick();
        req_valid = 4'h0;
        sreset    = 1'b0;
        tick();
        check("rst_credits", 32'(credits_avail), 32'd8);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_err", 32'(credit_err), 32'd0);

        // Single requester, uncontended
        req_valid = 4'b0100;
        req_data[2*WIDTH +: WIDTH] = 16'hBEEF;
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'h0;
        check("single_tx_valid", 32'(tx_valid), 32'd1);
        check("single_tx_data", 32'(tx_data), 32'hBEEF);
        check("single_tx_id", 32'(tx_id), 32'd2);
        check("single_credits", 32'(credits_avail), 32'd7);
        check("single_idle", 32'(idle), 32'd0);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        check("return_credits", 32'(credits_avail), 32'd8);
        check("return_idle", 32'(idle), 32'd1);
        check("return_tx_data_hold", 32'(tx_data), 32'hBEEF);

        // Full contention with credit_ret every cycle, from a fresh pointer
        sreset = 1'b1;
        tick();
        sreset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = 16'(16'hA000 + i);
        req_valid  = 4'hF;
        credit_ret = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
            tick();
            check("rr_tx_id", 32'(tx_id), 32'(i % 4));
            check("rr_tx_data", 32'(tx_data), 32'(16'hA000 + (i % 4)));
            check("rr_credits", 32'(credits_avail), 32'd8);
        end
        req_valid  = 4'h0;
        credit_ret = 1'b0;
        check("rr_no_err", 32'(credit_err), 32'd0);

        // Drain every credit with requester 0 alone
        req_valid = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_ready", 32'(req_ready), 32'b0001);
            tick();
            check("drain_credits", 32'(credits_avail), 32'(7 - i));
        end
        #1;
        check("empty_ready", 32'(req_ready), 32'h0);
        tick();
        check("empty_tx_valid", 32'(tx_valid), 32'd0);
        check("empty_credits", 32'(credits_avail), 32'd0);
        credit_ret = 1'b1;
        #1;
        check("zero_ret_no_grant", 32'(req_ready), 32'h0);
        tick();
        credit_ret = 1'b0;
        check("one_credit", 32'(credits_avail), 32'd1);
        check("one_credit_tx_valid", 32'(tx_valid), 32'd0);
        #1;
        check("one_credit_ready", 32'(req_ready), 32'b0001);
        tick();
        check("last_tx_valid", 32'(tx_valid), 32'd1);
        check("last_credits", 32'(credits_avail), 32'd0);
        #1;
        check("last_ready_off", 32'(req_ready), 32'h0);
        tick();
        check("last_tx_done", 32'(tx_valid), 32'd0);
        req_valid = 4'h0;

        // Refill, then overflow
        credit_ret = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        credit_ret = 1'b0;
        check("refill_credits", 32'(credits_avail), 32'd8);
        check("refill_idle", 32'(idle), 32'd1);
        check("refill_err", 32'(credit_err), 32'd0);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        check("ovf_credits", 32'(credits_avail), 32'd8);
        check("ovf_err", 32'(credit_err), 32'd1);
        tick();
        tick();
        check("ovf_err_sticky", 32'(credit_err), 32'd1);

        // Burst down to 3 credits (ptr is 1 here: grants 1,2,3,0,1), then reset mid-burst
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) tick();
        check("burst_credits", 32'(credits_avail), 32'd3);
        check("burst_tx_valid", 32'(tx_valid), 32'd1);
        check("burst_tx_id", 32'(tx_id), 32'd1);
        sreset = 1'b1;
        #1;
        check("burst_rst_ready", 32'(req_ready), 32'h0);
        tick();
        sreset = 1'b0;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_credits", 32'(credits_avail), 32'd8);
        check("mid_rst_err", 32'(credit_err), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd1);
        #1;
        check("mid_rst_ptr", 32'(req_ready), 32'b0001);
        tick();
        check("mid_rst_tx_id", 32'(tx_id), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'hA000);
        req_valid = 4'h0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
